axis_fifo_reader: RTL

Drains a first-word-fall-through FIFO (the team's `fifo`, `REGISTERED_OUTPUT=0`) and presents its contents as an AXI-Stream master with fixed-length packets. A `tlast` marker is asserted every `i_pkt_len` beats. A 2-entry output buffer keeps `o_fifo_r_stb` independent of `i_axis_tready` while sustaining one beat per cycle. The block sits directly downstream of the demo FIFO and feeds the stream sink.

---
 rtl/demo_axis_pkg.sv | 22 ++
 rtl/axis_skid_buffer.sv | 66 ++++++
 rtl/axis_fifo_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/demo_axis_pkg.sv
// ============================================================================
// demo_axis_pkg : shared FSM encoding and sizing constants for the AXIS demo
// Revision      : 1.0
// ============================================================================
`default_nettype none

package demo_axis_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } reader_state_t;

    localparam int unsigned BUF_DEPTH    = 2;
    localparam logic [1:0]  BUF_CNT_FULL = 2'(BUF_DEPTH);

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
// axis_skid_buffer : 2-entry FIFO-ordered buffer, head entry drives the output
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axis_skid_buffer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;

    // mem0 is always the head; mem1 only holds the second entry when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        mem0  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        mem0 <= push_data;
                    end else if (push) begin
                        mem1  <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        mem0 <= mem1;
                        if (push) begin
                            mem1 <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign head_data  = mem0;
    assign head_valid = (count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/axis_fifo_reader.sv
// ============================================================================
// axis_fifo_reader : drains an FWFT FIFO into a fixed-length-packet AXIS master
// Revision         : 1.0
// ============================================================================
`default_nettype none

module axis_fifo_reader
    import demo_axis_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic [LEN_W-1:0] i_pkt_len,
    input  logic [WIDTH-1:0] i_fifo_r_data,
    input  logic             i_fifo_not_empty,
    output logic             o_fifo_r_stb,
    output logic [WIDTH-1:0] o_axis_tdata,
    output logic             o_axis_tvalid,
    output logic             o_axis_tlast,
    input  logic             i_axis_tready,
    output logic [CNT_W-1:0] o_pkt_count,
    output logic             o_busy
);

    reader_state_t    state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] len_next;
    logic [1:0]       buf_count;
    logic [WIDTH:0]   head;
    logic             head_valid;
    logic             is_last;
    logic             pop_stb;
    logic             accept;

    assign len_next = (i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len;
    assign is_last  = (beat_q == (len_q - LEN_W'(1)));

    // Pop decision deliberately ignores tready: the spare buffer slot absorbs it.
    assign pop_stb  = (state == ST_ACTIVE) && i_fifo_not_empty && (buf_count != BUF_CNT_FULL);
    assign accept   = head_valid && i_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            len_q  <= LEN_W'(1);
            beat_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_enable) begin
                        state  <= ST_ACTIVE;
                        len_q  <= len_next;
                        beat_q <= '0;
                    end
                end
                default: begin
                    if (pop_stb) begin
                        if (is_last) begin
                            beat_q <= '0;
                            if (i_enable) begin
                                len_q <= len_next;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            beat_q <= beat_q + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pkt_count <= '0;
        end else if (accept && o_axis_tlast) begin
            o_pkt_count <= o_pkt_count + CNT_W'(1);
        end
    end

    axis_skid_buffer #(
        .WIDTH (WIDTH + 1)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pop_stb),
        .push_data  ({i_fifo_r_data, is_last}),
        .pop        (accept),
        .count      (buf_count),
        .head_data  (head),
        .head_valid (head_valid)
    );

    assign o_fifo_r_stb  = pop_stb;
    assign o_axis_tdata  = head[WIDTH:1];
    assign o_axis_tlast  = head[0] & head_valid;
    assign o_axis_tvalid = head_valid;
    assign o_busy        = (state == ST_ACTIVE) || (buf_count != 2'd0);

endmodule

`default_nettype wire
